// File: rtl/bsg_reset_seq_pkg.sv
// Shared types and table-indexing helper for the reset/bring-up sequencer.
package bsg_reset_seq_pkg;

  typedef enum logic [0:0] {
    eRun  = 1'b0,
    eDone = 1'b1
  } bsg_reset_seq_state_e;

  // Bit offset of entry idx in a flattened table of depth entries, each width bits
  // wide. idx is clamped so the done-state step index never reads past the table.
  function automatic int unsigned tbl_lsb(input int unsigned idx,
                                          input int unsigned width,
                                          input int unsigned depth);
    int unsigned clamped;
    clamped = (idx < depth) ? idx : depth - 1;
    return clamped * width;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Per-step delay counter: synchronous clear dominates, otherwise counts up when enabled.
module bsg_counter_clear_up #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_count <= '0;
    end else if (up_i) begin
      r_count <= r_count + width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_reset_sequencer.sv
// Power-on / link bring-up sequencer: walks sig_o through num_steps_p timed stages,
// with pause, restart and progress/done status.
module bsg_reset_sequencer
  import bsg_reset_seq_pkg::*;
#(
  parameter int unsigned num_sigs_p      = 4,
  parameter int unsigned num_steps_p     = 5,
  parameter int unsigned counter_width_p = 16,
  parameter logic [num_sigs_p-1:0] init_val_p = num_sigs_p'(4'b0100),
  parameter logic [num_steps_p-1:0][num_sigs_p-1:0] step_val_p = '0,
  parameter logic [num_steps_p-1:0][counter_width_p-1:0] step_delay_p =
    {num_steps_p{counter_width_p'(5000)}}
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               pause_i,
  input  logic                               restart_i,
  output logic [num_sigs_p-1:0]              sig_o,
  output logic [$clog2(num_steps_p+1)-1:0]   step_o,
  output logic                               done_o
);

  localparam int unsigned step_width_lp = $clog2(num_steps_p + 1);
  localparam logic [num_steps_p*num_sigs_p-1:0]      val_flat_lp   = step_val_p;
  localparam logic [num_steps_p*counter_width_p-1:0] delay_flat_lp = step_delay_p;
  localparam logic [step_width_lp-1:0] last_step_lp = step_width_lp'(num_steps_p - 1);

  bsg_reset_seq_state_e r_state, w_state_nxt;

  logic [num_sigs_p-1:0]      r_sig, w_sig_nxt, w_step_val;
  logic [step_width_lp-1:0]   r_step, w_step_nxt;
  logic                       r_done, w_done_nxt;
  logic [counter_width_p-1:0] w_count, w_step_delay;
  logic                       w_terminal, w_clear, w_up;

  assign w_step_val   = val_flat_lp[tbl_lsb(32'(r_step), num_sigs_p, num_steps_p) +: num_sigs_p];
  assign w_step_delay = delay_flat_lp[tbl_lsb(32'(r_step), counter_width_p, num_steps_p)
                                      +: counter_width_p];

  // Terminal count is checked even while paused: completion outranks pause.
  assign w_terminal = (r_state == eRun) && (w_count == w_step_delay);
  assign w_clear    = restart_i || w_terminal;
  assign w_up       = (r_state == eRun) && !pause_i;

  bsg_counter_clear_up #(
    .width_p (counter_width_p)
  ) u_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_clear),
    .up_i    (w_up),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_step_nxt  = r_step;
    w_done_nxt  = r_done;
    if (restart_i) begin
      w_state_nxt = eRun;
      w_sig_nxt   = init_val_p;
      w_step_nxt  = '0;
      w_done_nxt  = 1'b0;
    end else if (w_terminal) begin
      w_sig_nxt  = w_step_val;
      w_step_nxt = r_step + step_width_lp'(1);
      if (r_step == last_step_lp) begin
        w_state_nxt = eDone;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sig  <= init_val_p;
      r_step <= '0;
      r_done <= 1'b0;
    end else begin
      r_sig  <= w_sig_nxt;
      r_step <= w_step_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign sig_o  = r_sig;
  assign step_o = r_step;
  assign done_o = r_done;

endmodule

// File: tb/tb_bsg_reset_sequencer.sv
// Bench for bsg_reset_sequencer: a default-parameter instance and a small 3-step
// instance, each compared every cycle against a step/elapsed-time model.
`timescale 1ns/1ps
module tb_bsg_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: all defaults (4 sigs, 5 steps, 5000-cycle waits, all-zero values).
  logic       a_reset, a_pause, a_restart;
  logic [3:0] a_sig;
  logic [2:0] a_step;
  logic       a_done;

  bsg_reset_sequencer dut_a (
    .clk_i     (clk),
    .reset_i   (a_reset),
    .pause_i   (a_pause),
    .restart_i (a_restart),
    .sig_o     (a_sig),
    .step_o    (a_step),
    .done_o    (a_done)
  );

  // Instance B: delays {3,0,2}, values {01,10,11}, init 00.
  logic       b_reset, b_pause, b_restart;
  logic [1:0] b_sig;
  logic [1:0] b_step;
  logic       b_done;

  bsg_reset_sequencer #(
    .num_sigs_p      (2),
    .num_steps_p     (3),
    .counter_width_p (8),
    .init_val_p      (2'b00),
    .step_val_p      ({2'b11, 2'b10, 2'b01}),
    .step_delay_p    ({8'd2, 8'd0, 8'd3})
  ) dut_b (
    .clk_i     (clk),
    .reset_i   (b_reset),
    .pause_i   (b_pause),
    .restart_i (b_restart),
    .sig_o     (b_sig),
    .step_o    (b_step),
    .done_o    (b_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model: a sequence is "in step k, e cycles elapsed"; sig_o is the value of the
  // last completed step (or init before any), step_o is k, done when k reaches n.
  typedef struct packed {
    int k;
    int e;
    bit done;
    bit valid;
  } model_t;

  int cfg_n    [2];
  int cfg_init [2];
  int cfg_val  [2][8];
  int cfg_dly  [2][8];

  function automatic model_t model_next(model_t m, int c, bit rst, bit rs, bit pz);
    model_t r;
    r = m;
    if (rst || (m.valid && rs)) begin
      r.k = 0; r.e = 0; r.done = 1'b0; r.valid = 1'b1;
    end else if (!m.valid || m.done) begin
      r = m;
    end else if (m.e == cfg_dly[c][m.k]) begin
      r.k    = m.k + 1;
      r.e    = 0;
      r.done = (r.k == cfg_n[c]);
    end else if (!pz) begin
      r.e = m.e + 1;
    end
    return r;
  endfunction

  function automatic int exp_sig(model_t m, int c);
    return (m.k == 0) ? cfg_init[c] : cfg_val[c][m.k - 1];
  endfunction

  model_t ma, mb;

  // Compare process: outputs at each negedge reflect the previous posedge; inputs
  // are stable from posedge+2 so what is seen here is what the next edge samples.
  initial begin
    cfg_n[0] = 5; cfg_init[0] = 4;
    cfg_n[1] = 3; cfg_init[1] = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_val[0][i] = 0;
      cfg_dly[0][i] = 5000;
      cfg_val[1][i] = 0;
      cfg_dly[1][i] = 0;
    end
    cfg_val[1][0] = 1; cfg_val[1][1] = 2; cfg_val[1][2] = 3;
    cfg_dly[1][0] = 3; cfg_dly[1][1] = 0; cfg_dly[1][2] = 2;
    ma = '0;
    mb = '0;
    forever begin
      @(negedge clk);
      if (ma.valid) begin
        check("model_a_sig",  32'(a_sig),  exp_sig(ma, 0));
        check("model_a_step", 32'(a_step), ma.k);
        check("model_a_done", 32'(a_done), 32'(ma.done));
      end
      if (mb.valid) begin
        check("model_b_sig",  32'(b_sig),  exp_sig(mb, 1));
        check("model_b_step", 32'(b_step), mb.k);
        check("model_b_done", 32'(b_done), 32'(mb.done));
      end
      ma = model_next(ma, 0, a_reset, a_restart, a_pause);
      mb = model_next(mb, 1, b_reset, b_restart, b_pause);
    end
  end

  initial begin
    a_reset = 1'b1; a_pause = 1'b0; a_restart = 1'b0;
    b_reset = 1'b1; b_pause = 1'b0; b_restart = 1'b0;
    fork
      begin : seq_a
        tick(3);
        a_reset = 1'b0;                                // cycle 0
        check("a_reset_sig",  32'(a_sig),  32'h4);
        check("a_reset_step", 32'(a_step), 0);
        check("a_reset_done", 32'(a_done), 0);
        tick(5000);
        check("a_c5000_sig",  32'(a_sig),  32'h4);
        tick(1);
        check("a_c5001_sig",  32'(a_sig),  32'h0);
        check("a_c5001_step", 32'(a_step), 1);
        tick(20003);
        check("a_c25004_done", 32'(a_done), 0);
        check("a_c25004_step", 32'(a_step), 4);
        tick(1);
        check("a_c25005_done", 32'(a_done), 1);
        check("a_c25005_step", 32'(a_step), 5);
        a_pause = 1'b1;                                // no effect in eDone
        tick(5);
        a_pause = 1'b0;
        check("a_done_hold_step", 32'(a_step), 5);
        a_restart = 1'b1;
        tick(1);
        a_restart = 1'b0;                              // cycle 0 of rerun
        check("a_rst_done_sig",  32'(a_sig),  32'h4);
        check("a_rst_done_step", 32'(a_step), 0);
        check("a_rst_done_done", 32'(a_done), 0);
        tick(7001);                                    // mid-step 1
        a_pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
          tick(1);
          check("a_pause_step", 32'(a_step), 1);
          check("a_pause_sig",  32'(a_sig),  32'h0);
        end
        a_pause = 1'b0;                                // cycle 7011
        tick(10011 - 7011);
        check("a_pause_c10011_step", 32'(a_step), 1);
        tick(1);
        check("a_pause_c10012_step", 32'(a_step), 2);
        tick(2000);                                    // mid-step 2
        a_reset = 1'b1;
        tick(1);
        a_reset = 1'b0;                                // cycle 0 again
        check("a_midrst_sig",  32'(a_sig),  32'h4);
        check("a_midrst_step", 32'(a_step), 0);
        tick(5000);
        check("a_replay_c5000_step", 32'(a_step), 0);
        tick(1);
        check("a_replay_c5001_step", 32'(a_step), 1);
        tick(20004);
        check("a_replay_done", 32'(a_done), 1);
        check("a_replay_step", 32'(a_step), 5);
      end
      begin : seq_b
        tick(3);
        b_reset = 1'b0;                                // cycle 0
        check("b_reset_sig", 32'(b_sig), 0);
        tick(3);
        check("b_c3_sig", 32'(b_sig), 0);
        tick(1);
        check("b_c4_sig",  32'(b_sig),  1);
        check("b_c4_step", 32'(b_step), 1);
        tick(1);
        check("b_c5_sig",  32'(b_sig),  2);
        tick(2);
        check("b_c7_sig",  32'(b_sig),  2);
        check("b_c7_done", 32'(b_done), 0);
        tick(1);
        check("b_c8_sig",  32'(b_sig),  3);
        check("b_c8_done", 32'(b_done), 1);
        check("b_c8_step", 32'(b_step), 3);
        for (int i = 0; i < 100; i++) begin
          tick(1);
          check("b_hold_sig",  32'(b_sig),  3);
          check("b_hold_done", 32'(b_done), 1);
        end
        b_restart = 1'b1;
        tick(1);
        b_restart = 1'b0;                              // cycle 0
        check("b_rst_done_sig",  32'(b_sig),  0);
        check("b_rst_done_step", 32'(b_step), 0);
        tick(3);                                       // step 0 terminal count
        b_restart = 1'b1;
        tick(1);
        b_restart = 1'b0;
        check("b_rst_term_sig",  32'(b_sig),  0);
        check("b_rst_term_step", 32'(b_step), 0);
        tick(4);
        check("b_rst_term_replay_sig", 32'(b_sig), 1);
        for (int i = 0; i < 30000; i++) begin
          b_pause   = ($urandom_range(0, 3) == 0);
          b_restart = ($urandom_range(0, 199) == 0);
          b_reset   = ($urandom_range(0, 999) == 0);
          tick(1);
        end
        b_pause = 1'b0; b_restart = 1'b0; b_reset = 1'b0;
      end
    join
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
